// File: rtl/y86_fetch_aligner.sv
// Instruction-fetch aligner: fills a 12-byte queue from word-wide instruction memory and
// hands out 4-byte MIPS words or 1/2/5/6-byte Y86 instructions over a valid/ready handshake.
module y86_fetch_aligner #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic        RESET_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        redirect_mode,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [47:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] next_inst_pc,
    output logic        mode,
    output logic        inst_bad
);
    logic [95:0] r_queue;
    logic [3:0]  r_count;
    logic [31:0] r_cur_pc;
    logic        r_mode;
    logic        r_pending;
    logic        r_drop;
    logic [1:0]  r_off;

    logic [2:0]  w_len;
    logic        w_bad;
    logic [47:0] w_len_mask;
    logic        w_inst_valid;
    logic        w_xfer;
    logic        w_req;
    logic        w_append;
    logic [31:0] w_fill_addr;
    logic [95:0] w_queue_c;
    logic [3:0]  w_count_c;
    logic [31:0] w_rdata_sh;
    logic [2:0]  w_app_n;
    logic [95:0] w_append_bits;

    // Instruction length and validity from queue byte 0 and the current mode
    always_comb begin
        w_len = 3'd4;
        w_bad = 1'b0;
        if (r_mode) begin
            case (r_queue[7:4])
                4'h0, 4'h1, 4'h9:       w_len = 3'd1;
                4'h2, 4'h6, 4'hA, 4'hB: w_len = 3'd2;
                4'h7, 4'h8:             w_len = 3'd5;
                4'h3, 4'h4, 4'h5:       w_len = 3'd6;
                default: begin
                    w_len = 3'd1;
                    w_bad = 1'b1;
                end
            endcase
        end else begin
            w_len = 3'd4;
            w_bad = (r_cur_pc[1:0] != 2'b00);
        end
    end

    // Byte mask that zeroes everything past the instruction length
    always_comb begin
        w_len_mask = 48'h0000_0000_0000;
        case (w_len)
            3'd1:    w_len_mask = 48'h0000_0000_00FF;
            3'd2:    w_len_mask = 48'h0000_0000_FFFF;
            3'd4:    w_len_mask = 48'h0000_FFFF_FFFF;
            3'd5:    w_len_mask = 48'h00FF_FFFF_FFFF;
            3'd6:    w_len_mask = 48'hFFFF_FFFF_FFFF;
            default: w_len_mask = 48'h0000_0000_0000;
        endcase
    end

    assign w_inst_valid = (r_count >= {1'b0, w_len}) && !redirect;
    assign w_xfer       = w_inst_valid && inst_ready;
    assign w_fill_addr  = r_cur_pc + {28'd0, r_count};
    // Requests depend only on registered state and redirect, never on inst_ready
    assign w_req        = resetn && !r_pending && (r_count <= 4'd8) && !redirect;
    assign w_append     = imem_rvalid && r_pending && !r_drop;

    // Bytes above r_count are always zero, so the append can be OR-ed into place
    assign w_queue_c     = w_xfer ? (r_queue >> {w_len, 3'b000}) : r_queue;
    assign w_count_c     = w_xfer ? (r_count - {1'b0, w_len}) : r_count;
    assign w_rdata_sh    = imem_rdata >> {r_off, 3'b000};
    assign w_app_n       = 3'd4 - {1'b0, r_off};
    assign w_append_bits = {64'd0, w_rdata_sh} << {w_count_c, 3'b000};

    // Queue, PC, mode and outstanding-read bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_queue   <= 96'd0;
            r_count   <= 4'd0;
            r_cur_pc  <= RESET_PC;
            r_mode    <= RESET_MODE;
            r_pending <= 1'b0;
            r_drop    <= 1'b0;
            r_off     <= 2'd0;
        end else if (redirect) begin
            r_queue   <= 96'd0;
            r_count   <= 4'd0;
            r_cur_pc  <= redirect_pc;
            r_mode    <= redirect_mode;
            r_pending <= r_pending && !imem_rvalid;
            r_drop    <= r_pending && !imem_rvalid;
        end else begin
            r_cur_pc <= w_xfer ? (r_cur_pc + {29'd0, w_len}) : r_cur_pc;
            if (w_append) begin
                r_queue <= w_queue_c | w_append_bits;
                r_count <= w_count_c + {1'b0, w_app_n};
            end else begin
                r_queue <= w_queue_c;
                r_count <= w_count_c;
            end
            if (w_req) begin
                r_pending <= 1'b1;
                r_off     <= w_fill_addr[1:0];
            end else if (imem_rvalid) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end
            r_drop <= imem_rvalid ? 1'b0 : r_drop;
        end
    end

    assign imem_req     = w_req;
    assign imem_addr    = {w_fill_addr[31:2], 2'b00};
    assign inst_valid   = w_inst_valid;
    assign inst         = w_inst_valid ? (r_queue[47:0] & w_len_mask) : 48'd0;
    assign inst_pc      = r_cur_pc;
    assign next_inst_pc = r_cur_pc + {29'd0, w_len};
    assign mode         = r_mode;
    assign inst_bad     = w_inst_valid && w_bad;

endmodule

// File: tb/tb_y86_fetch_aligner.sv
// Self-checking bench for y86_fetch_aligner: a byte-array memory, a walk-the-program
// reference model, and directed plus randomized scenarios.
module tb_y86_fetch_aligner;
    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        redirect_mode;
    logic        inst_valid;
    logic        inst_ready;
    logic [47:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] next_inst_pc;
    logic        mode;
    logic        inst_bad;

    always #5 clk = ~clk;

    y86_fetch_aligner #(.RESET_PC(32'h0000_0000), .RESET_MODE(1'b0)) dut (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .redirect_mode(redirect_mode),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .next_inst_pc(next_inst_pc), .mode(mode), .inst_bad(inst_bad)
    );

    logic [7:0]  mem [0:4095];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          xfer_count = 0;
    logic        mem_busy = 1'b0;
    int          mem_due = 0;
    logic [31:0] mem_word = 32'h0;
    int          mem_lat = 1;
    logic        lat_random = 1'b0;
    logic        req_seen = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    logic        exp_mode = 1'b0;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [47:0] obs_inst;
    logic [31:0] obs_pc;
    logic [31:0] obs_next;
    logic        obs_bad;

    logic [47:0] log_inst [$];
    logic [31:0] log_pc [$];
    logic [31:0] log_next [$];
    logic        log_bad [$];

    function automatic int ref_len(input logic [31:0] pc, input logic md);
        logic [3:0] op;
        if (!md) return 4;
        op = mem[pc[11:0]][7:4];
        if (op == 4'h0 || op == 4'h1 || op == 4'h9) return 1;
        if (op == 4'h2 || op == 4'h6 || op == 4'hA || op == 4'hB) return 2;
        if (op == 4'h7 || op == 4'h8) return 5;
        if (op >= 4'h3 && op <= 4'h5) return 6;
        return 1;
    endfunction

    function automatic logic ref_bad(input logic [31:0] pc, input logic md);
        logic [3:0] op;
        if (!md) return (pc[1:0] != 2'b00);
        op = mem[pc[11:0]][7:4];
        return (op > 4'hB);
    endfunction

    function automatic logic [47:0] ref_inst(input logic [31:0] pc, input int len);
        logic [47:0] v;
        logic [31:0] a;
        v = 48'h0;
        for (int k = 0; k < len; k++) begin
            a = pc + 32'(k);
            v[8*k +: 8] = mem[a[11:0]];
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {mem[{a[11:2], 2'd3}], mem[{a[11:2], 2'd2}], mem[{a[11:2], 2'd1}], mem[{a[11:2], 2'd0}]};
    endfunction

    task automatic clear_log();
        log_inst.delete();
        log_pc.delete();
        log_next.delete();
        log_bad.delete();
    endtask

    // One clock: memory response, observation, model update; starts and ends 1 unit after posedge
    task automatic cycle();
        int          lat;
        int          len;
        logic [47:0] e_inst;
        logic        e_bad;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mem_busy && cyc >= mem_due) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word;
            mem_busy    = 1'b0;
        end
        @(negedge clk);
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = inst_valid;
        obs_inst  = inst;
        obs_pc    = inst_pc;
        obs_next  = next_inst_pc;
        obs_bad   = inst_bad;
        if (imem_req) begin
            checks++;
            if (mem_busy || !resetn || imem_addr[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL imem_protocol: addr=%h busy=%b resetn=%b, required word-aligned addr, no outstanding read, reset released",
                         imem_addr, mem_busy, resetn);
            end
            lat      = lat_random ? int'($urandom_range(1, 4)) : mem_lat;
            mem_busy = 1'b1;
            mem_due  = cyc + lat;
            mem_word = ref_word(imem_addr);
            req_seen = 1'b1;
        end
        if (resetn && redirect) begin
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_valid: inst_valid=%b required 0", inst_valid);
            end
        end else if (resetn && inst_valid && inst_ready) begin
            len    = ref_len(exp_pc, exp_mode);
            e_inst = ref_inst(exp_pc, len);
            e_bad  = ref_bad(exp_pc, exp_mode);
            checks++;
            if (inst !== e_inst || inst_pc !== exp_pc || next_inst_pc !== exp_pc + 32'(len) ||
                inst_bad !== e_bad || mode !== exp_mode) begin
                errors++;
                $display("FAIL xfer: got inst=%h pc=%h next=%h bad=%b mode=%b, expected inst=%h pc=%h next=%h bad=%b mode=%b",
                         inst, inst_pc, next_inst_pc, inst_bad, mode,
                         e_inst, exp_pc, exp_pc + 32'(len), e_bad, exp_mode);
            end
            log_inst.push_back(inst);
            log_pc.push_back(inst_pc);
            log_next.push_back(next_inst_pc);
            log_bad.push_back(inst_bad);
            xfer_count++;
            exp_pc = exp_pc + 32'(len);
        end
        if (!resetn) begin
            exp_pc   = 32'h0;
            exp_mode = 1'b0;
        end else if (redirect) begin
            exp_pc   = redirect_pc;
            exp_mode = redirect_mode;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_redirect(input logic [31:0] pc, input logic md);
        redirect      = 1'b1;
        redirect_pc   = pc;
        redirect_mode = md;
        cycle();
        redirect      = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (log_pc.size() < n && i < budget) begin
            cycle();
            i++;
        end
        checks++;
        if (log_pc.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: transfers=%0d required>=%0d", name, log_pc.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (2) cycle();
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 48'h0 || inst_bad !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b valid=%b inst=%h bad=%b required 0 0 0 0", imem_req, inst_valid, inst, inst_bad);
        end
        checks++;
        if (inst_pc !== 32'h0 || next_inst_pc !== 32'h4 || mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc: pc=%h next=%h mode=%b required 0 4 0", inst_pc, next_inst_pc, mode);
        end
        clear_log();
        resetn = 1'b1;
        cycle();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_request: req=%b addr=%h required 1 00000000", obs_req, obs_addr);
        end
    endtask

    task automatic test_mips_stream();
        run_until(2, 30, "mips");
        if (log_pc.size() >= 2) begin
            checks++;
            if (log_inst[0] !== 48'h0000_2008_0005 || log_pc[0] !== 32'h0 || log_next[0] !== 32'h4) begin
                errors++;
                $display("FAIL mips_first: inst=%h pc=%h next=%h required 000020080005 0 4", log_inst[0], log_pc[0], log_next[0]);
            end
            checks++;
            if (log_inst[1] !== 48'h0000_0109_5020 || log_pc[1] !== 32'h4 || log_next[1] !== 32'h8) begin
                errors++;
                $display("FAIL mips_second: inst=%h pc=%h next=%h required 000001095020 4 8", log_inst[1], log_pc[1], log_next[1]);
            end
        end
    endtask

    task automatic test_y86_sequence();
        logic [7:0] prog [0:8];
        prog = '{8'h30, 8'hF2, 8'h78, 8'h56, 8'h34, 8'h12, 8'h60, 8'h21, 8'h10};
        for (int k = 0; k < 9; k++) mem[k + 1] = prog[k];
        clear_log();
        do_redirect(32'h1, 1'b1);
        run_until(3, 60, "y86");
        if (log_pc.size() >= 3) begin
            checks++;
            if (log_inst[0] !== 48'h1234_5678_F230 || log_pc[0] !== 32'h1 || log_next[0] !== 32'h7) begin
                errors++;
                $display("FAIL y86_irmovl: inst=%h pc=%h next=%h required 12345678f230 1 7", log_inst[0], log_pc[0], log_next[0]);
            end
            checks++;
            if (log_inst[1] !== 48'h0000_0000_2160 || log_next[1] !== 32'h9) begin
                errors++;
                $display("FAIL y86_opl: inst=%h next=%h required 2160 9", log_inst[1], log_next[1]);
            end
            checks++;
            if (log_inst[2] !== 48'h0000_0000_0010 || log_next[2] !== 32'hA) begin
                errors++;
                $display("FAIL y86_nop: inst=%h next=%h required 10 a", log_inst[2], log_next[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] s_inst;
        logic [31:0] s_pc;
        logic [31:0] s_next;
        logic        s_bad;
        inst_ready = 1'b0;
        mem_lat    = 1;
        do_redirect(32'h200, 1'b1);
        repeat (10) cycle();
        s_inst = obs_inst;
        s_pc   = obs_pc;
        s_next = obs_next;
        s_bad  = obs_bad;
        checks++;
        if (obs_valid !== 1'b1 || s_pc !== 32'h200) begin
            errors++;
            $display("FAIL bp_filled: valid=%b pc=%h required 1 00000200", obs_valid, s_pc);
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_inst !== s_inst || obs_pc !== s_pc ||
                obs_next !== s_next || obs_bad !== s_bad) begin
                errors++;
                $display("FAIL bp_hold: req=%b valid=%b inst=%h pc=%h next=%h required req 0, valid 1, inst=%h pc=%h next=%h",
                         obs_req, obs_valid, obs_inst, obs_pc, obs_next, s_inst, s_pc, s_next);
            end
        end
        clear_log();
        req_seen   = 1'b0;
        inst_ready = 1'b1;
        run_until(6, 80, "bp_drain");
        checks++;
        if (req_seen !== 1'b1) begin
            errors++;
            $display("FAIL bp_refill: request seen=%b required 1", req_seen);
        end
    endtask

    task automatic test_redirect_latency();
        inst_ready = 1'b0;
        mem_lat    = 1;
        repeat (10) cycle();
        do_redirect(32'h40, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checks++;
            if (obs_valid !== (k == 3)) begin
                errors++;
                $display("FAIL redirect_latency: cycle %0d valid=%b required %b", k, obs_valid, (k == 3));
            end
        end
        inst_ready = 1'b1;
    endtask

    task automatic test_redirect_pending();
        int i;
        mem_lat = 3;
        obs_req = 1'b0;
        i = 0;
        while (!obs_req && i < 20) begin
            cycle();
            i++;
        end
        checks++;
        if (!obs_req) begin
            errors++;
            $display("FAIL pending_setup: req=%b required 1", obs_req);
        end
        clear_log();
        do_redirect(32'h100, 1'b1);
        obs_req = 1'b0;
        i = 0;
        while (!obs_req && i < 20) begin
            cycle();
            i++;
        end
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
            errors++;
            $display("FAIL pending_refetch: req=%b addr=%h required 1 00000100", obs_req, obs_addr);
        end
        run_until(1, 40, "pending");
        if (log_pc.size() >= 1) begin
            checks++;
            if (log_pc[0] !== 32'h100) begin
                errors++;
                $display("FAIL pending_first_pc: pc=%h required 00000100", log_pc[0]);
            end
        end
        mem_lat = 1;
    endtask

    task automatic test_invalid();
        mem[12'h300] = 8'hF0;
        clear_log();
        do_redirect(32'h300, 1'b1);
        run_until(1, 30, "bad_y86");
        if (log_pc.size() >= 1) begin
            checks++;
            if (log_bad[0] !== 1'b1 || log_next[0] !== 32'h301 || log_inst[0] !== 48'h0000_0000_00F0) begin
                errors++;
                $display("FAIL bad_y86: bad=%b next=%h inst=%h required 1 00000301 f0", log_bad[0], log_next[0], log_inst[0]);
            end
        end
        clear_log();
        do_redirect(32'h102, 1'b0);
        run_until(1, 30, "bad_mips");
        if (log_pc.size() >= 1) begin
            checks++;
            if (log_bad[0] !== 1'b1 || log_pc[0] !== 32'h102 || log_next[0] !== 32'h106) begin
                errors++;
                $display("FAIL bad_mips: bad=%b pc=%h next=%h required 1 00000102 00000106", log_bad[0], log_pc[0], log_next[0]);
            end
        end
    endtask

    task automatic test_random();
        int n0;
        n0 = xfer_count;
        lat_random = 1'b1;
        for (int i = 0; i < 600; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0)
                do_redirect(32'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
            else
                cycle();
        end
        lat_random = 1'b0;
        inst_ready = 1'b1;
        checks++;
        if (xfer_count - n0 < 20) begin
            errors++;
            $display("FAIL random_progress: transfers=%0d required>=20", xfer_count - n0);
        end
    endtask

    task automatic test_reset_midfetch();
        int i;
        mem_lat = 3;
        obs_req = 1'b0;
        i = 0;
        while (!obs_req && i < 20) begin
            cycle();
            i++;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 48'h0 || inst_bad !== 1'b0 ||
            inst_pc !== 32'h0 || next_inst_pc !== 32'h4 || mode !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: req=%b valid=%b inst=%h bad=%b pc=%h next=%h mode=%b required 0 0 0 0 0 4 0",
                     imem_req, inst_valid, inst, inst_bad, inst_pc, next_inst_pc, mode);
        end
        repeat (5) cycle();
        clear_log();
        resetn = 1'b1;
        cycle();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_first_request: req=%b addr=%h required 1 00000000", obs_req, obs_addr);
        end
        run_until(2, 40, "midreset");
        if (log_pc.size() >= 2) begin
            checks++;
            if (log_pc[0] !== 32'h0 || log_pc[1] !== 32'h4 || log_inst[0] !== ref_inst(32'h0, 4)) begin
                errors++;
                $display("FAIL midreset_stream: pc0=%h pc1=%h inst0=%h required 0 4 %h",
                         log_pc[0], log_pc[1], log_inst[0], ref_inst(32'h0, 4));
            end
        end
        mem_lat = 1;
    endtask

    initial begin
        resetn        = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        redirect_mode = 1'b0;
        inst_ready    = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom_range(0, 255));
        {mem[3], mem[2], mem[1], mem[0]} = 32'h2008_0005;
        {mem[7], mem[6], mem[5], mem[4]} = 32'h0109_5020;
        #1;
        test_reset();
        test_mips_stream();
        test_y86_sequence();
        test_backpressure();
        test_redirect_latency();
        test_redirect_pending();
        test_invalid();
        test_random();
        test_reset_midfetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
